// File: rtl/clb_config_loader.sv
// clb_config_loader
// Bit-serial configuration loader for a column of NUM_PAIRS logic pairs.
// A valid/ready stream delivers one frame per pair, LSB first, pair 0 first:
// LUT[15:0], switch, carryOut_sel_mux (and a parity bit when enabled).
// Completed frames collect in shadow registers. After the last bit of the
// last frame, all committed outputs load from the shadows on the same edge,
// and one COMMIT cycle then pulses prgm_b/CLB_prgm_b low.
//
// Build option: define CFG_PARITY_EN for 19-bit frames with even parity.
// A parity mismatch moves the FSM to ERR and nothing is committed. Without
// the macro, frames are 18 bits and cfg_err is constant 0.
module clb_config_loader #(
  parameter int NUM_PAIRS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_start,
  input  logic                      cfg_abort,
  input  logic                      cfg_data,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [16*NUM_PAIRS-1:0]   look_up_t,
  output logic [NUM_PAIRS-1:0]      switch,
  output logic [NUM_PAIRS-1:0]      carryOut_sel_mux,
  output logic                      prgm_b,
  output logic                      CLB_prgm_b,
  output logic                      cfg_done,
  output logic                      cfg_err
);

`ifdef CFG_PARITY_EN
  localparam int FRAME_LEN = 19;
`else
  localparam int FRAME_LEN = 18;
`endif
  localparam int                PAIR_W    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [4:0]        LAST_BIT  = 5'(FRAME_LEN - 1);
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_COMMIT = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  state_e                   state_q;
  logic [4:0]               bit_cnt_q;
  logic [PAIR_W-1:0]        pair_cnt_q;

  logic [FRAME_LEN-1:0]     frame_q, frame_d;
  logic [16*NUM_PAIRS-1:0]  sh_lut_q, sh_lut_d;
  logic [NUM_PAIRS-1:0]     sh_sw_q, sh_sw_d;
  logic [NUM_PAIRS-1:0]     sh_co_q, sh_co_d;

  logic [16*NUM_PAIRS-1:0]  lut_q;
  logic [NUM_PAIRS-1:0]     sw_q;
  logic [NUM_PAIRS-1:0]     co_q;
  logic                     cfg_ready_q;
  logic                     prgm_b_q;
  logic                     clb_prgm_b_q;
  logic                     cfg_done_q;
  logic                     cfg_err_q;

  logic                     xfer;
  logic                     frame_end;
  logic                     last_pair;
  logic                     start_load;
  logic                     parity_bad;

  // Handshake and frame-boundary decode. An abort on the same edge drops the bit.
  always_comb begin
    xfer       = (state_q == S_LOAD) && cfg_valid && !cfg_abort;
    frame_end  = xfer && (bit_cnt_q == LAST_BIT);
    last_pair  = (pair_cnt_q == LAST_PAIR);
    start_load = cfg_start &&
                 ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  end

  // Assemble the current frame, including the bit being accepted, and derive
  // the shadow contents as they will be after this edge.
  // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    frame_d            = frame_q;
    frame_d[bit_cnt_q] = cfg_data;
    sh_lut_d           = sh_lut_q;
    sh_sw_d            = sh_sw_q;
    sh_co_d            = sh_co_q;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (frame_end && (pair_cnt_q == PAIR_W'(p))) begin
        sh_lut_d[16*p +: 16] = frame_d[15:0];
        sh_sw_d[p]           = frame_d[16];
        sh_co_d[p]           = frame_d[17];
      end
    end
`ifdef CFG_PARITY_EN
    // Even parity: the XOR over all 19 frame bits must be zero.
    parity_bad = ^frame_d;
`else
    parity_bad = 1'b0;
`endif
  end

  // Frame assembly and shadow storage; an abort discards everything collected.
  // NOTE: the shadows are ordinary flops and get an explicit reset; a RAM-style store would be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q  <= '0;
      sh_lut_q <= '0;
      sh_sw_q  <= '0;
      sh_co_q  <= '0;
    end else if ((state_q == S_LOAD) && cfg_abort) begin
      frame_q  <= '0;
      sh_lut_q <= '0;
      sh_sw_q  <= '0;
      sh_co_q  <= '0;
    end else if (xfer) begin
      frame_q  <= frame_end ? '0 : frame_d;
      sh_lut_q <= sh_lut_d;
      sh_sw_q  <= sh_sw_d;
      sh_co_q  <= sh_co_d;
    end
  end

  // Control FSM with counters and registered outputs. The committed outputs
  // load from the shadows on the same edge that accepts the final bit.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      pair_cnt_q   <= '0;
      lut_q        <= '0;
      sw_q         <= '0;
      co_q         <= '0;
      cfg_ready_q  <= 1'b0;
      prgm_b_q     <= 1'b1;
      clb_prgm_b_q <= 1'b1;
      cfg_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_load) begin
            state_q     <= S_LOAD;
            bit_cnt_q   <= '0;
            pair_cnt_q  <= '0;
            cfg_ready_q <= 1'b1;
            prgm_b_q    <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
          end
        end

        S_LOAD: begin
          if (cfg_abort) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            pair_cnt_q  <= '0;
            cfg_ready_q <= 1'b0;
            prgm_b_q    <= 1'b1;
          end else if (frame_end) begin
            bit_cnt_q <= '0;
            if (parity_bad) begin
              state_q     <= S_ERR;
              pair_cnt_q  <= '0;
              cfg_ready_q <= 1'b0;
              prgm_b_q    <= 1'b1;
              cfg_err_q   <= 1'b1;
            end else if (last_pair) begin
              state_q      <= S_COMMIT;
              pair_cnt_q   <= '0;
              cfg_ready_q  <= 1'b0;
              clb_prgm_b_q <= 1'b0;
              lut_q        <= sh_lut_d;
              sw_q         <= sh_sw_d;
              co_q         <= sh_co_d;
            end else begin
              pair_cnt_q <= pair_cnt_q + PAIR_W'(1);
            end
          end else if (xfer) begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
          end
        end

        S_COMMIT: begin
          state_q      <= S_DONE;
          prgm_b_q     <= 1'b1;
          clb_prgm_b_q <= 1'b1;
          cfg_done_q   <= 1'b1;
        end

        default: begin
          state_q      <= S_IDLE;
          cfg_ready_q  <= 1'b0;
          prgm_b_q     <= 1'b1;
          clb_prgm_b_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready        = cfg_ready_q;
  assign look_up_t        = lut_q;
  assign switch           = sw_q;
  assign carryOut_sel_mux = co_q;
  assign prgm_b           = prgm_b_q;
  assign CLB_prgm_b       = clb_prgm_b_q;
  assign cfg_done         = cfg_done_q;
  assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_clb_config_loader.sv
// Bench for clb_config_loader (NUM_PAIRS = 4): table-driven full loads plus
// hand-written abort, mid-load reset, ignored-start and parity sequences.
module tb_clb_config_loader;

  localparam int NP = 4;
`ifdef CFG_PARITY_EN
  localparam int F = 19;
`else
  localparam int F = 18;
`endif
  localparam int MAX_CYC = 400;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_start = 1'b0;
  logic            cfg_abort = 1'b0;
  logic            cfg_data = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [16*NP-1:0] lut_o;
  logic [NP-1:0]   sw_o;
  logic [NP-1:0]   co_o;
  logic            prgm_b;
  logic            clb_prgm_b;
  logic            cfg_done;
  logic            cfg_err;

  clb_config_loader #(.NUM_PAIRS(NP)) dut (
    .clk              (clk),
    .reset            (rst_n),
    .cfg_start        (cfg_start),
    .cfg_abort        (cfg_abort),
    .cfg_data         (cfg_data),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .look_up_t        (lut_o),
    .switch           (sw_o),
    .carryOut_sel_mux (co_o),
    .prgm_b           (prgm_b),
    .CLB_prgm_b       (clb_prgm_b),
    .cfg_done         (cfg_done),
    .cfg_err          (cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Bench model of the committed outputs, updated only from stimulus.
  logic [63:0] m_lut = '0;
  logic [3:0]  m_sw  = '0;
  logic [3:0]  m_co  = '0;

  bit err_seen = 1'b0;
  always @(posedge clk) if (cfg_err === 1'b1) err_seen <= 1'b1;

  typedef struct {
    logic [63:0] luts;
    logic [3:0]  sw;
    logic [3:0]  co;
    bit          toggle;
    int          exp_load;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_committed(input string tag, input logic [63:0] luts,
                                 input logic [3:0] sw, input logic [3:0] co);
    check({tag, "_lut"}, lut_o, luts);
    check({tag, "_switch"}, {60'd0, sw_o}, {60'd0, sw});
    check({tag, "_carry"}, {60'd0, co_o}, {60'd0, co});
  endtask

  // Serialises one load and observes it cycle by cycle (samples #1 after
  // each rising edge). cut_at >= 0 stops after that many accepted bits, by
  // abort (cut_reset=0) or by asserting reset (cut_reset=1). poke_at pulses
  // cfg_start alongside that bit. bad_frame flips one frame's parity bit.
  task automatic do_load(input logic [63:0] luts, input logic [3:0] sw, input logic [3:0] co,
                         input bit toggle, input int cut_at, input bit cut_reset,
                         input int poke_at, input int bad_frame,
                         output int load_cyc, output int commit_cyc, output int done_cyc);
    logic [NP*F-1:0] stream;
    int  sent;
    bit  phase, accept, stable, commit_ok;
    stream = '0;
    for (int p = 0; p < NP; p++) begin
      for (int b = 0; b < 16; b++) stream[p*F+b] = luts[p*16+b];
      stream[p*F+16] = sw[p];
      stream[p*F+17] = co[p];
`ifdef CFG_PARITY_EN
      stream[p*F+18] = (^{luts[p*16 +: 16], sw[p], co[p]}) ^ (p == bad_frame);
`endif
    end
    load_cyc = 0; commit_cyc = 0; done_cyc = -1;
    sent = 0; phase = 1'b1; stable = 1'b1; commit_ok = 1'b1;

    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    check("ready_after_start", {63'd0, cfg_ready}, 64'd1);
    check("done_clear_in_load", {63'd0, cfg_done}, 64'd0);
    check("err_clear_in_load", {63'd0, cfg_err}, 64'd0);

    for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
      if (cfg_done === 1'b1 || cfg_err === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (cfg_ready === 1'b1) begin
        load_cyc++;
        if (lut_o !== m_lut || sw_o !== m_sw || co_o !== m_co || prgm_b !== 1'b0) stable = 1'b0;
      end
      if (clb_prgm_b !== 1'b1) begin
        commit_cyc++;
        if (prgm_b !== 1'b0 || lut_o !== luts || sw_o !== sw || co_o !== co) commit_ok = 1'b0;
      end
      accept = 1'b0;
      if (cfg_ready === 1'b1) begin
        if (sent == cut_at) begin
          if (cut_reset) begin
            #2 rst_n = 1'b0;
            cfg_valid = 1'b0;
          end else begin
            cfg_abort = 1'b1;
            cfg_valid = 1'b1;
            cfg_data  = stream[sent];
            @(posedge clk); #1;
            cfg_abort = 1'b0;
            cfg_valid = 1'b0;
          end
          check("stable_before_cut", {63'd0, stable}, 64'd1);
          return;
        end
        cfg_valid = toggle ? phase : 1'b1;
        phase     = ~phase;
        cfg_data  = stream[sent];
        cfg_start = (sent == poke_at);
        accept    = cfg_valid;
      end else begin
        cfg_valid = 1'b0;
      end
      @(posedge clk); #1;
      cfg_start = 1'b0;
      if (accept) sent++;
    end
    cfg_valid = 1'b0;
    if (done_cyc < 0) check("load_timeout", 64'd0, 64'd1);
    check("outputs_stable_in_load", {63'd0, stable}, 64'd1);
    check("outputs_valid_in_commit", {63'd0, commit_ok}, 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check_committed(tag, 64'd0, 4'd0, 4'd0);
    check({tag, "_ctrl"}, {58'd0, prgm_b, clb_prgm_b, cfg_ready, cfg_done, cfg_err, 1'b0},
          {58'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  int lc, cc, dc;

  initial begin
    // Pair i: LUT 16'hA5A0+i, switch = i[0], carryOut_sel_mux = ~i[0].
    vecs[0] = '{luts: 64'hA5A3_A5A2_A5A1_A5A0, sw: 4'b1010, co: 4'b0101, toggle: 1'b0, exp_load: NP*F};
    vecs[1] = '{luts: 64'hA5A3_A5A2_A5A1_A5A0, sw: 4'b1010, co: 4'b0101, toggle: 1'b1, exp_load: 2*NP*F-1};
    vecs[2] = '{luts: 64'h0123_4567_89AB_CDEF, sw: 4'b1100, co: 4'b0011, toggle: 1'b1, exp_load: 2*NP*F-1};
    vecs[3] = '{luts: 64'hFFFF_FFFF_FFFF_FFFF, sw: 4'b0000, co: 4'b1111, toggle: 1'b0, exp_load: NP*F};

    // Reset state, both while held and after release; valid in IDLE is ignored.
    repeat (3) @(posedge clk);
    #1 check_reset_values("in_reset");
    @(negedge clk) rst_n = 1'b1;
    cfg_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_values("idle");
    cfg_valid = 1'b0;

    // Full loads from the table.
    for (int v = 0; v < 4; v++) begin
      do_load(vecs[v].luts, vecs[v].sw, vecs[v].co, vecs[v].toggle, -1, 1'b0, -1, -1, lc, cc, dc);
      check($sformatf("v%0d_load_cycles", v), lc, vecs[v].exp_load);
      check($sformatf("v%0d_commit_cycles", v), cc, 1);
      check($sformatf("v%0d_done_cycle", v), dc, vecs[v].exp_load + 2);
      check_committed($sformatf("v%0d", v), vecs[v].luts, vecs[v].sw, vecs[v].co);
      check($sformatf("v%0d_done_ctrl", v), {61'd0, cfg_done, prgm_b, clb_prgm_b}, 64'b111);
      m_lut = vecs[v].luts; m_sw = vecs[v].sw; m_co = vecs[v].co;
    end

    // Abort after 30 bits: committed FFFF values stay, FSM idles.
    do_load(64'h1234_5678_9ABC_DEF0, 4'b0110, 4'b1001, 1'b0, 30, 1'b0, -1, -1, lc, cc, dc);
    #20;
    check_committed("abort", 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 4'b1111);
    check("abort_idle", {61'd0, cfg_ready, cfg_done, prgm_b}, 64'b001);

    // cfg_start pulsed at bit 10 is ignored; the load completes normally.
    do_load(vecs[0].luts, vecs[0].sw, vecs[0].co, 1'b0, -1, 1'b0, 10, -1, lc, cc, dc);
    check("poke_load_cycles", lc, NP*F);
    check("poke_done_cycle", dc, NP*F + 2);
    check_committed("poke", vecs[0].luts, vecs[0].sw, vecs[0].co);
    m_lut = vecs[0].luts; m_sw = vecs[0].sw; m_co = vecs[0].co;

    // Reset after 40 bits, then a fresh load succeeds.
    do_load(vecs[2].luts, vecs[2].sw, vecs[2].co, 1'b0, 40, 1'b1, -1, -1, lc, cc, dc);
    repeat (2) @(posedge clk);
    #1 check_reset_values("midload_reset");
    @(negedge clk) rst_n = 1'b1;
    m_lut = '0; m_sw = '0; m_co = '0;
    @(posedge clk); #1;
    do_load(vecs[2].luts, vecs[2].sw, vecs[2].co, 1'b0, -1, 1'b0, -1, -1, lc, cc, dc);
    check("after_reset_done_cycle", dc, NP*F + 2);
    check_committed("after_reset", vecs[2].luts, vecs[2].sw, vecs[2].co);
    m_lut = vecs[2].luts; m_sw = vecs[2].sw; m_co = vecs[2].co;

`ifdef CFG_PARITY_EN
    // Bad parity in frame 2: ERR, no commit strobe, outputs retained.
    do_load(vecs[3].luts, vecs[3].sw, vecs[3].co, 1'b0, -1, 1'b0, -1, 2, lc, cc, dc);
    check("parity_err", {62'd0, cfg_err, cfg_done}, 64'b10);
    check("parity_no_commit", cc, 0);
    check("parity_load_cycles", lc, 3*F);
    check_committed("parity", vecs[2].luts, vecs[2].sw, vecs[2].co);
    // Restart from ERR: the in-task checks confirm cfg_err clears.
    do_load(vecs[0].luts, vecs[0].sw, vecs[0].co, 1'b0, -1, 1'b0, -1, -1, lc, cc, dc);
    check_committed("after_err", vecs[0].luts, vecs[0].sw, vecs[0].co);
`else
    check("err_never_seen", {63'd0, err_seen}, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
